// File: rtl/ring_monitor.sv
// Receive-side checker for an 8-bit one-hot ring counter: decodes the active position,
// locks onto a cleanly advancing ring, counts revolutions and flags illegal patterns.
module ring_monitor #(
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q7,
    input  logic             q6,
    input  logic             q5,
    input  logic             q4,
    input  logic             q3,
    input  logic             q2,
    input  logic             q1,
    input  logic             q0,
    input  logic             en,
    input  logic             err_clr,
    output logic [2:0]       idx,
    output logic             onehot_ok,
    output logic             locked,
    output logic             err,
    output logic [REV_W-1:0] rev_cnt
);

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

    state_t             state, state_next;
    logic [2:0]         p, p_next;
    logic [3:0]         good, good_next;
    logic [2:0]         idx_next;
    logic               onehot_ok_next, locked_next, err_next, err_set;
    logic [REV_W-1:0]   rev_next;

    logic [7:0] v;
    logic [2:0] pos;
    logic       is_onehot, is_adv, is_hold;
    logic [3:0] good_inc;

    assign v         = {q7, q6, q5, q4, q3, q2, q1, q0};
    assign is_onehot = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    // The 3-bit add wraps 7 -> 0, matching the ring's fixed rotation direction.
    assign is_adv    = is_onehot && (pos == p + 3'd1);
    assign is_hold   = is_onehot && (pos == p);
    assign good_inc  = good + 4'd1;

    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) pos = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            p         <= 3'd0;
            good      <= 4'd0;
            idx       <= 3'd0;
            onehot_ok <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            rev_cnt   <= '0;
        end else begin
            state     <= state_next;
            p         <= p_next;
            good      <= good_next;
            idx       <= idx_next;
            onehot_ok <= onehot_ok_next;
            locked    <= locked_next;
            err       <= err_next;
            rev_cnt   <= rev_next;
        end
    end

    always_comb begin
        state_next     = state;
        p_next         = p;
        good_next      = good;
        idx_next       = idx;
        onehot_ok_next = onehot_ok;
        locked_next    = locked;
        rev_next       = rev_cnt;
        err_set        = 1'b0;

        if (en) begin
            onehot_ok_next = is_onehot;
            if (is_onehot) idx_next = pos;

            case (state)
                HUNT: begin
                    if (is_onehot) begin
                        p_next     = pos;
                        good_next  = 4'd0;
                        state_next = TRACK;
                    end
                end
                TRACK: begin
                    if (is_adv) begin
                        good_next = good_inc;
                        p_next    = pos;
                        if (good_inc == LOCK_TARGET) begin
                            state_next  = LOCKED;
                            locked_next = 1'b1;
                        end
                    end else if (!is_hold) begin
                        state_next = HUNT;
                        good_next  = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_adv) begin
                        p_next = pos;
                        if (p == 3'd7 && pos == 3'd0) rev_next = rev_cnt + REV_W'(1);
                    end else if (!is_hold) begin
                        // The offending sample is discarded; HUNT re-acquires on the next one.
                        err_set     = 1'b1;
                        locked_next = 1'b0;
                        state_next  = HUNT;
                    end
                end
                default: state_next = HUNT;
            endcase
        end

        err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
    end

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the ring-checking rules.
module tb_ring_monitor;

    localparam int LOCK_CNT = 2;
    localparam int REV_W    = 8;

    logic             clk = 1'b0;
    logic             rst, en, err_clr;
    logic [7:0]       qv;
    logic [2:0]       idx;
    logic             onehot_ok, locked, err;
    logic [REV_W-1:0] rev_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model: phase 0 = searching, 1 = confirming, 2 = locked.
    int               m_phase, m_prev, m_good;
    logic [2:0]       m_idx;
    logic             m_ok, m_locked, m_err;
    logic [REV_W-1:0] m_rev;

    always #5 clk = ~clk;

    ring_monitor #(.LOCK_CNT(LOCK_CNT), .REV_W(REV_W)) dut (
        .clk(clk), .rst(rst),
        .q7(qv[7]), .q6(qv[6]), .q5(qv[5]), .q4(qv[4]),
        .q3(qv[3]), .q2(qv[2]), .q1(qv[1]), .q0(qv[0]),
        .en(en), .err_clr(err_clr),
        .idx(idx), .onehot_ok(onehot_ok), .locked(locked), .err(err), .rev_cnt(rev_cnt)
    );

    function automatic int bit_pos(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] ring_vec(input int position);
        logic [7:0] one = 8'd1;
        return one << (position % 8);
    endfunction

    function automatic logic [13:0] dut_vec();
        return {idx, onehot_ok, locked, err, rev_cnt};
    endfunction

    function automatic logic [13:0] model_vec();
        return {m_idx, m_ok, m_locked, m_err, m_rev};
    endfunction

    function automatic string dut_str();
        return $sformatf("idx=%0d ok=%b locked=%b err=%b rev=%0d", idx, onehot_ok, locked, err, rev_cnt);
    endfunction

    function automatic string model_str();
        return $sformatf("idx=%0d ok=%b locked=%b err=%b rev=%0d", m_idx, m_ok, m_locked, m_err, m_rev);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_prev = 0; m_good = 0;
        m_idx = 3'd0; m_ok = 1'b0; m_locked = 1'b0; m_err = 1'b0; m_rev = '0;
    endtask

    task automatic model_step(input logic [7:0] v, input logic e, input logic clr);
        logic oh, bad_locked;
        int   pos;
        bad_locked = 1'b0;
        if (e) begin
            oh  = ($countones(v) == 1);
            pos = bit_pos(v);
            m_ok = oh;
            if (oh) m_idx = 3'(pos);
            if (m_phase == 0) begin
                if (oh) begin m_prev = pos; m_good = 0; m_phase = 1; end
            end else if (oh && pos == (m_prev + 1) % 8) begin
                if (m_phase == 2 && m_prev == 7) m_rev = m_rev + 1'b1;
                m_prev = pos;
                if (m_phase == 1) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_phase = 2; m_locked = 1'b1; end
                end
            end else if (!(oh && pos == m_prev)) begin
                if (m_phase == 2) begin bad_locked = 1'b1; m_locked = 1'b0; end
                m_phase = 0; m_good = 0;
            end
        end
        m_err = bad_locked ? 1'b1 : (clr ? 1'b0 : m_err);
    endtask

    // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next edge.
    task automatic drive(input logic [7:0] v, input logic e, input logic clr);
        qv = v; en = e; err_clr = clr;
        @(posedge clk);
        model_step(v, e, clr);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; err_clr = 1'b0; qv = 8'd0;
        model_reset();
        #2;
        n_vec++;
        if (dut_vec() !== 14'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %s want all zero", dut_str());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_acquisition();
        logic [7:0] seq [3] = '{8'h01, 8'h02, 8'h04};
        for (int i = 0; i < 3; i++) begin
            drive(seq[i], 1'b1, 1'b0);
            n_vec++;
            if (dut_vec() !== model_vec() || idx !== 3'(i) || onehot_ok !== 1'b1 ||
                locked !== (i == 2) || err !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL acquisition[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
    endtask

    task automatic test_revolutions();
        for (int i = 0; i < 14; i++) begin
            drive(ring_vec(i + 3), 1'b1, 1'b0);
            n_vec++;
            if (dut_vec() !== model_vec() || locked !== 1'b1 || err !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL revolutions[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
        n_vec++;
        if (rev_cnt !== 8'd2 || idx !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL revolutions_total: got rev=%0d idx=%0d want rev=2 idx=0", rev_cnt, idx);
        end
    endtask

    task automatic test_illegal_pattern();
        logic [7:0] seq [3] = '{8'h01, 8'h02, 8'h04};
        drive(8'h06, 1'b1, 1'b0);
        n_vec++;
        if (dut_vec() !== model_vec() || err !== 1'b1 || locked !== 1'b0 ||
            onehot_ok !== 1'b0 || idx !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL illegal_two_bits: got %s want %s", dut_str(), model_str());
        end
        for (int i = 0; i < 3; i++) begin
            drive(seq[i], 1'b1, 1'b0);
            n_vec++;
            if (dut_vec() !== model_vec() || err !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL relock[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
        n_vec++;
        if (locked !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL relock_sticky: got locked=%b err=%b want locked=1 err=1", locked, err);
        end
    endtask

    task automatic test_err_clr();
        drive(8'h04, 1'b1, 1'b1);
        n_vec++;
        if (dut_vec() !== model_vec() || err !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_clr_alone: got %s want %s", dut_str(), model_str());
        end
        drive(8'h01, 1'b1, 1'b1);
        n_vec++;
        if (dut_vec() !== model_vec() || err !== 1'b1 || locked !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_set_wins: got %s want %s", dut_str(), model_str());
        end
        for (int i = 1; i <= 3; i++) begin
            drive(ring_vec(i), 1'b1, 1'b0);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL reacquire[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
    endtask

    task automatic test_skip();
        for (int i = 4; i <= 8; i++) begin
            drive(ring_vec(i), 1'b1, (i == 4));
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL skip_setup[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
        drive(8'h04, 1'b1, 1'b0);
        n_vec++;
        if (dut_vec() !== model_vec() || err !== 1'b1 || locked !== 1'b0 || idx !== 3'd2) begin
            n_fail++;
            $display("[TB] FAIL skip_position: got %s want %s", dut_str(), model_str());
        end
        for (int i = 3; i <= 5; i++) begin
            drive(ring_vec(i), 1'b1, 1'b0);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL skip_relock[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
    endtask

    task automatic test_hold_enable();
        logic [13:0] snap;
        for (int i = 6; i <= 11; i++) begin
            drive(ring_vec(i), 1'b1, (i == 6));
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL hold_setup[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
        snap = model_vec();
        for (int i = 0; i < 5; i++) begin
            drive(8'h08, 1'b1, 1'b0);
            n_vec++;
            if (dut_vec() !== snap || err !== 1'b0 || locked !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL hold[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(8'hFF, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== snap) begin
                n_fail++;
                $display("[TB] FAIL enable_low[%0d]: got %s want %s", i, dut_str(), model_str());
            end
        end
    endtask

    task automatic test_random();
        int cur, r, p;
        logic [7:0] v;
        logic e, clr;
        cur = int'(m_idx);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            e = 1'b1;
            if (r < 55) begin
                cur = (cur + 1) % 8; v = ring_vec(cur);
            end else if (r < 70) begin
                v = ring_vec(cur);
            end else if (r < 80) begin
                v = 8'($urandom);
                if ($countones(v) == 1) cur = bit_pos(v);
            end else if (r < 90) begin
                p = $urandom_range(0, 7); cur = p; v = ring_vec(p);
            end else begin
                v = 8'($urandom); e = 1'b0;
            end
            clr = ($urandom_range(0, 19) == 0);
            drive(v, e, clr);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] v=%b en=%b clr=%b: got %s want %s",
                         n, v, e, clr, dut_str(), model_str());
            end
        end
    endtask

    task automatic test_reset_midrun();
        int k;
        drive(8'h00, 1'b0, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        k = 0;
        for (int i = 0; i < 3 + 40; i++) begin
            drive(ring_vec(i), 1'b1, 1'b0);
        end
        drive(8'h06, 1'b1, 1'b0);
        for (int i = 3; i <= 5; i++) drive(ring_vec(i), 1'b1, 1'b0);
        n_vec++;
        if (dut_vec() !== model_vec() || locked !== 1'b1 || err !== 1'b1 || rev_cnt !== 8'd5) begin
            n_fail++;
            $display("[TB] FAIL midrun_setup: got %s want locked=1 err=1 rev=5", dut_str());
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (dut_vec() !== 14'd0) begin
            n_fail++;
            $display("[TB] FAIL midrun_async_clear: got %s want all zero", dut_str());
        end
        #2 rst = 1'b1;
        for (int i = 4; i <= 6; i++) begin
            drive(ring_vec(i), 1'b1, 1'b0);
            k++;
            n_vec++;
            if (dut_vec() !== model_vec() || locked !== (k == 3) || idx !== 3'(i) || rev_cnt !== 8'd0) begin
                n_fail++;
                $display("[TB] FAIL midrun_reacquire[%0d]: got %s want %s", k, dut_str(), model_str());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_acquisition();
        test_revolutions();
        test_illegal_pattern();
        test_err_clr();
        test_skip();
        test_hold_enable();
        test_random();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
